// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator:
// FSM state type, one-hot result encoding {g, eq, l} and the
// WIDTH/CHUNK legality check used at elaboration.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } cmp_state_t;

  // Result vector ordering is {y_g, y_eq, y_l}.
  localparam logic [2:0] RES_G  = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_L  = 3'b001;

  // Chunk size must tile the operand exactly.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational compare of one CHUNK-bit slice. With signed_en set the
// slice is treated as two's complement; flipping the sign bit of both
// sides turns the signed compare into an unsigned one.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             signed_en,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] a_biased;
  logic [CHUNK-1:0] b_biased;

  // Bias the sign bit so a plain unsigned compare orders signed values.
  always_comb begin
    a_biased = a;
    b_biased = b;
    a_biased[CHUNK-1] = a[CHUNK-1] ^ signed_en;
    b_biased[CHUNK-1] = b[CHUNK-1] ^ signed_en;
  end

  // Magnitude flags from the biased slices.
  always_comb begin
    gt = (a_biased > b_biased);
    lt = (a_biased < b_biased);
    eq = (a_biased == b_biased);
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices MSB first and
// stops on the first differing slice. Only the top slice honours
// signed_mode. Optional macro CMP_CASCADE_EN adds 7485-style cascade
// inputs (cas_g/cas_eq/cas_l) that decide the all-equal result.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CMP   | comparing slice idx, one slice per cycle
// DONE  | result held on y_* with out_valid until out_ready
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
`ifdef CMP_CASCADE_EN
  input  logic             cas_g,
  input  logic             cas_eq,
  input  logic             cas_l,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y_g,
  output logic             y_eq,
  output logic             y_l,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $error("seq_mag_comparator: WIDTH must be a multiple of CHUNK and CHUNK in 1..WIDTH");
  end

  cmp_state_t       state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sm_reg;
  logic [2:0]       res, res_next;
  logic [2:0]       eq_res;
  logic             load;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic             c_gt, c_eq, c_lt;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a         (a_chunks[idx]),
    .b         (b_chunks[idx]),
    .signed_en (sm_reg && (idx == IDX_TOP)),
    .gt        (c_gt),
    .eq        (c_eq),
    .lt        (c_lt)
  );

`ifdef CMP_CASCADE_EN
  logic [2:0] cas_reg;
  assign eq_res = cas_reg;

  // Cascade bits are captured with the operands and passed through as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cas_reg <= '0;
    else if (load) cas_reg <= {cas_g, cas_eq, cas_l};
  end
`else
  assign eq_res = RES_EQ;
`endif

  // Next-state, slice index and result selection.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    res_next   = res;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          idx_next   = IDX_TOP;
          state_next = CMP;
        end
      end
      CMP: begin
        if (!c_eq) begin
          // {gt, 0, lt} lines up with RES_G / RES_L.
          res_next   = {c_gt, 1'b0, c_lt};
          state_next = DONE;
        end else if (idx == '0) begin
          res_next   = eq_res;
          state_next = DONE;
        end else begin
          idx_next = idx - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          res_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        res_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State, index, result and operand capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= IDX_TOP;
      res    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      sm_reg <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      res   <= res_next;
      if (load) begin
        a_reg  <= a;
        b_reg  <= b;
        sm_reg <= signed_mode;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CMP);
  assign out_valid = (state == DONE);
  assign {y_g, y_eq, y_l} = res;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator (WIDTH=16, CHUNK=4). Cascade
// vectors run only when CMP_CASCADE_EN is defined.
module tb_seq_mag_comparator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic        y_g, y_eq, y_l;
  logic        busy;
`ifdef CMP_CASCADE_EN
  logic        cas_g, cas_eq, cas_l;
`endif

  int vectors = 0;
  int errs    = 0;

  seq_mag_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
`ifdef CMP_CASCADE_EN
    .cas_g       (cas_g),
    .cas_eq      (cas_eq),
    .cas_l       (cas_l),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y_g         (y_g),
    .y_eq        (y_eq),
    .y_l         (y_l),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge, then scramble the inputs.
  task automatic start(input logic [15:0] av, input logic [15:0] bv, input logic sm);
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    signed_mode = ~sm;
  endtask

  // Count cycles until out_valid (bounded) and check latency/busy/flags.
  task automatic wait_result(input string tag, input logic [2:0] exp_flags, input int exp_k);
    int cycles = 0;
    int busy_cnt = 0;
    while (!out_valid && cycles < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_latency"}, cycles, exp_k);
    check({tag, "_busy_cycles"}, busy_cnt, exp_k);
    check({tag, "_flags"}, {29'b0, y_g, y_eq, y_l}, {29'b0, exp_flags});
    check({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_cleared"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_flags_cleared"}, {29'b0, y_g, y_eq, y_l}, 32'd0);
    check({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
`ifdef CMP_CASCADE_EN
    cas_g = 1'b0; cas_eq = 1'b0; cas_l = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_flags", {29'b0, y_g, y_eq, y_l}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All chunks equal: full walk, equal result.
    start(16'h1234, 16'h1234, 1'b0);
    wait_result("eq_1234", 3'b010, 4);
    handshake("eq_1234");

    // Top chunk decides immediately.
    start(16'h8000, 16'h7FFF, 1'b0);
    wait_result("u_8000_7fff", 3'b100, 1);
    handshake("u_8000_7fff");

    start(16'h8000, 16'h7FFF, 1'b1);
    wait_result("s_8000_7fff", 3'b001, 1);
    handshake("s_8000_7fff");

    // Differ in chunk 1.
    start(16'h12A4, 16'h12B4, 1'b0);
    wait_result("u_12a4_12b4", 3'b001, 3);
    handshake("u_12a4_12b4");

    // Signed: -1 < 1 decided at the top chunk.
    start(16'hFFFF, 16'h0001, 1'b1);
    wait_result("s_ffff_0001", 3'b001, 1);
    handshake("s_ffff_0001");

    // Signed mode, lower chunks compared unsigned: 0xA > 0x5.
    start(16'hF00A, 16'hF005, 1'b1);
    wait_result("s_f00a_f005", 3'b100, 4);
    handshake("s_f00a_f005");

    // Hold result with out_ready low; an in_valid pulse must be ignored.
    start(16'h0F00, 16'h0E00, 1'b0);
    wait_result("hold", 3'b100, 2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 16'h0000; b = 16'hFFFF; in_valid = 1'b1;
      end
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_flags", {29'b0, y_g, y_eq, y_l}, 32'd4);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    handshake("hold");
    check("hold_pulse_not_accepted", {31'b0, busy}, 32'd0);

    // Asynchronous reset two cycles into a compare.
    start(16'h1234, 16'h1234, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_flags", {29'b0, y_g, y_eq, y_l}, 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start(16'h5678, 16'h5679, 1'b0);
    wait_result("post_rst", 3'b001, 4);
    handshake("post_rst");

`ifdef CMP_CASCADE_EN
    // All-equal result comes from the latched cascade bits.
    cas_g = 1'b0; cas_eq = 1'b0; cas_l = 1'b1;
    start(16'h00FF, 16'h00FF, 1'b0);
    cas_g = 1'b1; cas_l = 1'b0;
    wait_result("cas_eq_l", 3'b001, 4);
    handshake("cas_eq_l");

    cas_g = 1'b0; cas_eq = 1'b0; cas_l = 1'b1;
    start(16'h0100, 16'h00FF, 1'b0);
    wait_result("cas_diff", 3'b100, 2);
    handshake("cas_diff");

    // Non-one-hot cascade passes through unchanged.
    cas_g = 1'b1; cas_eq = 1'b0; cas_l = 1'b1;
    start(16'hABCD, 16'hABCD, 1'b1);
    wait_result("cas_raw", 3'b101, 4);
    handshake("cas_raw");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
